// File: rtl/vga_timing_pkg.sv
// ---------------------------------------------------------------------------
// vga_timing_pkg
// Shared definitions for the VGA raster timing generator:
//   - default 640x480@60 timing constants and the H/V total derivation
//   - pixel struct (r, g, b) carried from the pixel source to the pins
//   - colour-bar enumeration and colour lookup for the optional test pattern
//     (enabled with the VGA_TIMING_TESTPAT_EN macro in vga_timing_gen)
// ---------------------------------------------------------------------------
package vga_timing_pkg;

  // Default horizontal timing, in pixel clocks
  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;

  // Default vertical timing, in lines
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;

  // Pixel-source latency defaults and the largest latency the delay line supports
  localparam int DEF_FETCH_LAT = 2;
  localparam int MAX_FETCH_LAT = 7;
  localparam int DEF_CW        = 10;

  // A raster dimension is active + front porch + sync + back porch
  function automatic int totalOf(input int active, input int fp,
                                 input int sync, input int bp);
    return active + fp + sync + bp;
  endfunction

  localparam int DEF_H_TOTAL = totalOf(DEF_H_ACTIVE, DEF_H_FP, DEF_H_SYNC, DEF_H_BP);
  localparam int DEF_V_TOTAL = totalOf(DEF_V_ACTIVE, DEF_V_FP, DEF_V_SYNC, DEF_V_BP);

  // One 24-bit pixel as it travels to the DAC
  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } pixel_t;

  // Colour bars, left to right across the visible line
  typedef enum logic [2:0] {
    BAR_WHITE   = 3'd0,
    BAR_YELLOW  = 3'd1,
    BAR_CYAN    = 3'd2,
    BAR_GREEN   = 3'd3,
    BAR_MAGENTA = 3'd4,
    BAR_RED     = 3'd5,
    BAR_BLUE    = 3'd6,
    BAR_BLACK   = 3'd7
  } bar_e;

  localparam pixel_t COLOUR_WHITE   = pixel_t'(24'hFFFFFF);
  localparam pixel_t COLOUR_YELLOW  = pixel_t'(24'hFFFF00);
  localparam pixel_t COLOUR_CYAN    = pixel_t'(24'h00FFFF);
  localparam pixel_t COLOUR_GREEN   = pixel_t'(24'h00FF00);
  localparam pixel_t COLOUR_MAGENTA = pixel_t'(24'hFF00FF);
  localparam pixel_t COLOUR_RED     = pixel_t'(24'hFF0000);
  localparam pixel_t COLOUR_BLUE    = pixel_t'(24'h0000FF);
  localparam pixel_t COLOUR_BLACK   = pixel_t'(24'h000000);

  // Map a bar index to its full-intensity colour
  function automatic pixel_t barColour(input bar_e bar);
    pixel_t colour;
    case (bar)
      BAR_WHITE:   colour = COLOUR_WHITE;
      BAR_YELLOW:  colour = COLOUR_YELLOW;
      BAR_CYAN:    colour = COLOUR_CYAN;
      BAR_GREEN:   colour = COLOUR_GREEN;
      BAR_MAGENTA: colour = COLOUR_MAGENTA;
      BAR_RED:     colour = COLOUR_RED;
      BAR_BLUE:    colour = COLOUR_BLUE;
      default:     colour = COLOUR_BLACK;
    endcase
    return colour;
  endfunction

endpackage

// File: rtl/vga_delay_line.sv
// ---------------------------------------------------------------------------
// vga_delay_line
// Parametrised shift register: i_data appears on o_data DEPTH clocks later.
// DEPTH = 0 is a plain wire. Asynchronous active-low clear loads every stage
// with CLEAR_VAL so the pipe drains a known (blank, unsynced) value.
// Ports:
//   i_clk    clock
//   i_rst_n  asynchronous active-low clear
//   i_data   WIDTH-bit word entering the pipe
//   o_data   WIDTH-bit word leaving the pipe
// ---------------------------------------------------------------------------
module vga_delay_line #(
  parameter int               DEPTH     = 2,
  parameter int               WIDTH     = 1,
  parameter logic [WIDTH-1:0] CLEAR_VAL = '0
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [WIDTH-1:0] i_data,
  output logic [WIDTH-1:0] o_data
);

  generate
    if (DEPTH == 0) begin : g_bypass
      // Zero latency: the source is combinational, nothing to store
      assign o_data = i_data;
    end else begin : g_shift
      logic [WIDTH-1:0] r_stage [DEPTH];

      // Stage 0 takes the new word; every later stage takes its neighbour
      always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
          for (int i = 0; i < DEPTH; i++) begin
            r_stage[i] <= CLEAR_VAL;
          end
        end else begin
          r_stage[0] <= i_data;
          for (int i = 1; i < DEPTH; i++) begin
            r_stage[i] <= r_stage[i-1];
          end
        end
      end

      assign o_data = r_stage[DEPTH-1];
    end
  endgenerate

endmodule

// File: rtl/vga_timing_gen.sv
// ---------------------------------------------------------------------------
// vga_timing_gen
// VGA raster timing generator with a pixel-fetch lookahead port. The fetch
// stage publishes the coordinate to read FETCH_LAT clocks ahead; sync and
// blank travel through a matching delay line so that colour, sync and blank
// reach the pins registered and aligned.
//
// Optional feature macro: VGA_TIMING_TESTPAT_EN
//   adds input pattern_sel; when high the pins show 8 vertical colour bars
//   instead of R_in/G_in/B_in.
//
// Ports:
//   CLOCK_25               pixel clock
//   RESET_N                asynchronous active-low reset
//   ENABLE                 run control; low holds the raster at origin, blanked
//   pattern_sel            (macro only) select colour-bar test pattern
//   R_in/G_in/B_in         colour for the coordinate fetched FETCH_LAT clocks ago
//   next_x/next_y          coordinate to fetch (0 when not visible)
//   next_valid             next_x/next_y is a visible pixel
//   frame_start            first fetch of a frame
//   line_start             first fetch of each visible line
//   VGA_CLK                copy of CLOCK_25
//   VGA_HS/VGA_VS          syncs, asserted level set by HS_POL/VS_POL
//   VGA_R/VGA_G/VGA_B      pixel colour, 0 outside the visible area
//   VGA_BLANK_N            high during visible output pixels
//   VGA_SYNC_N             constant 1
// ---------------------------------------------------------------------------
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int H_ACTIVE  = DEF_H_ACTIVE,
  parameter int H_FP      = DEF_H_FP,
  parameter int H_SYNC    = DEF_H_SYNC,
  parameter int H_BP      = DEF_H_BP,
  parameter int V_ACTIVE  = DEF_V_ACTIVE,
  parameter int V_FP      = DEF_V_FP,
  parameter int V_SYNC    = DEF_V_SYNC,
  parameter int V_BP      = DEF_V_BP,
  parameter bit HS_POL    = 1'b0,
  parameter bit VS_POL    = 1'b0,
  parameter int FETCH_LAT = DEF_FETCH_LAT,
  parameter int CW        = DEF_CW
) (
  input  logic          CLOCK_25,
  input  logic          RESET_N,
  input  logic          ENABLE,
`ifdef VGA_TIMING_TESTPAT_EN
  input  logic          pattern_sel,
`endif
  input  logic [7:0]    R_in,
  input  logic [7:0]    G_in,
  input  logic [7:0]    B_in,
  output logic [CW-1:0] next_x,
  output logic [CW-1:0] next_y,
  output logic          next_valid,
  output logic          frame_start,
  output logic          line_start,
  output logic          VGA_CLK,
  output logic          VGA_HS,
  output logic          VGA_VS,
  output logic [7:0]    VGA_R,
  output logic [7:0]    VGA_G,
  output logic [7:0]    VGA_B,
  output logic          VGA_BLANK_N,
  output logic          VGA_SYNC_N
);

  // Raster geometry, pre-sized to the counter width so compares are exact.
  // FETCH_LAT is expected to lie in 0..MAX_FETCH_LAT.
  localparam int H_TOTAL = totalOf(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int V_TOTAL = totalOf(V_ACTIVE, V_FP, V_SYNC, V_BP);

  localparam logic [CW-1:0] H_LAST     = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST     = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] H_ACT_C    = CW'(H_ACTIVE);
  localparam logic [CW-1:0] V_ACT_C    = CW'(V_ACTIVE);
  localparam logic [CW-1:0] HS_BEGIN_C = CW'(H_ACTIVE + H_FP);
  localparam logic [CW-1:0] HS_END_C   = CW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CW-1:0] VS_BEGIN_C = CW'(V_ACTIVE + V_FP);
  localparam logic [CW-1:0] VS_END_C   = CW'(V_ACTIVE + V_FP + V_SYNC);

  // The delayed x is only consumed by the bar generator, so it only rides
  // the delay line when that generator exists.
`ifdef VGA_TIMING_TESTPAT_EN
  localparam int DLY_W = 3 + CW;
`else
  localparam int DLY_W = 3;
`endif

  // Fetch counters and registered fetch-stage outputs
  logic [CW-1:0] r_h;
  logic [CW-1:0] r_v;
  logic [CW-1:0] r_nextX;
  logic [CW-1:0] r_nextY;
  logic          r_nextValid;
  logic          r_frameStart;
  logic          r_lineStart;
  logic          r_hsFetch;
  logic          r_vsFetch;

  // Combinational decode of the current count
  logic w_valid;
  logic w_hsRaw;
  logic w_vsRaw;

  // Delay line bundle
  logic [DLY_W-1:0] w_dlyIn;
  logic [DLY_W-1:0] w_dlyOut;
  logic             w_dlyHs;
  logic             w_dlyVs;
  logic             w_dlyValid;

  // Output stage
  pixel_t w_pix;
  pixel_t r_pix;
  logic   r_vgaHs;
  logic   r_vgaVs;
  logic   r_blankN;

  // Raster counters: h runs every enabled clock, v steps on the h wrap, and
  // both wrap together at the last pixel of the frame. Disabling parks the
  // raster at the origin so that re-enabling starts a fresh frame.
  always_ff @(posedge CLOCK_25 or negedge RESET_N) begin
    if (!RESET_N) begin
      r_h <= '0;
      r_v <= '0;
    end else if (!ENABLE) begin
      r_h <= '0;
      r_v <= '0;
    end else if (r_h == H_LAST) begin
      r_h <= '0;
      r_v <= (r_v == V_LAST) ? '0 : r_v + 1'b1;
    end else begin
      r_h <= r_h + 1'b1;
    end
  end

  // Region decode; gating with ENABLE makes a disabled raster look blank
  // and unsynced to everything downstream.
  always_comb begin
    w_valid = ENABLE && (r_h < H_ACT_C) && (r_v < V_ACT_C);
    w_hsRaw = ENABLE && (r_h >= HS_BEGIN_C) && (r_h < HS_END_C);
    w_vsRaw = ENABLE && (r_v >= VS_BEGIN_C) && (r_v < VS_END_C);
  end

  // Fetch stage registers: coordinate, qualifiers and raw syncs are all
  // registered together so they describe the same raster position.
  always_ff @(posedge CLOCK_25 or negedge RESET_N) begin
    if (!RESET_N) begin
      r_nextX      <= '0;
      r_nextY      <= '0;
      r_nextValid  <= 1'b0;
      r_frameStart <= 1'b0;
      r_lineStart  <= 1'b0;
      r_hsFetch    <= 1'b0;
      r_vsFetch    <= 1'b0;
    end else begin
      r_nextX      <= w_valid ? r_h : '0;
      r_nextY      <= w_valid ? r_v : '0;
      r_nextValid  <= w_valid;
      r_frameStart <= w_valid && (r_h == '0) && (r_v == '0);
      r_lineStart  <= w_valid && (r_h == '0);
      r_hsFetch    <= w_hsRaw;
      r_vsFetch    <= w_vsRaw;
    end
  end

  // Pack sync/valid (and x when needed) for the trip through the delay line
`ifdef VGA_TIMING_TESTPAT_EN
  assign w_dlyIn = {r_hsFetch, r_vsFetch, r_nextValid, r_nextX};
`else
  assign w_dlyIn = {r_hsFetch, r_vsFetch, r_nextValid};
`endif

  // Matches the pixel source latency so sync/blank meet their colour
  vga_delay_line #(
    .DEPTH     (FETCH_LAT),
    .WIDTH     (DLY_W),
    .CLEAR_VAL (DLY_W'(0))
  ) u_delay (
    .i_clk   (CLOCK_25),
    .i_rst_n (RESET_N),
    .i_data  (w_dlyIn),
    .o_data  (w_dlyOut)
  );

  assign w_dlyHs    = w_dlyOut[DLY_W-1];
  assign w_dlyVs    = w_dlyOut[DLY_W-2];
  assign w_dlyValid = w_dlyOut[DLY_W-3];

`ifdef VGA_TIMING_TESTPAT_EN
  logic [CW-1:0] w_dlyX;
  assign w_dlyX = w_dlyOut[CW-1:0];

  // Bar index floor(x*8/H_ACTIVE): x reaches bar k exactly when
  // x >= ceil(k*H_ACTIVE/8), so count the thresholds passed instead of dividing.
  function automatic bar_e barIndex(input logic [CW-1:0] x);
    logic [2:0] idx;
    idx = 3'd0;
    for (int k = 1; k < 8; k++) begin
      if (x >= CW'((k * H_ACTIVE + 7) / 8)) begin
        idx = idx + 3'd1;
      end
    end
    return bar_e'(idx);
  endfunction

  // Colour source: test bars when selected, otherwise the pixel source
  always_comb begin
    w_pix = {R_in, G_in, B_in};
    if (pattern_sel) begin
      w_pix = barColour(barIndex(w_dlyX));
    end
  end
`else
  // Colour always comes straight from the pixel source
  always_comb begin
    w_pix = {R_in, G_in, B_in};
  end
`endif

  // Output stage: sync, blank and colour are registered on the same edge,
  // and colour is forced to black whenever the pixel is not visible.
  always_ff @(posedge CLOCK_25 or negedge RESET_N) begin
    if (!RESET_N) begin
      r_vgaHs  <= ~HS_POL;
      r_vgaVs  <= ~VS_POL;
      r_blankN <= 1'b0;
      r_pix    <= '0;
    end else begin
      r_vgaHs  <= w_dlyHs ? HS_POL : ~HS_POL;
      r_vgaVs  <= w_dlyVs ? VS_POL : ~VS_POL;
      r_blankN <= w_dlyValid;
      r_pix    <= w_dlyValid ? w_pix : '0;
    end
  end

  assign next_x      = r_nextX;
  assign next_y      = r_nextY;
  assign next_valid  = r_nextValid;
  assign frame_start = r_frameStart;
  assign line_start  = r_lineStart;
  assign VGA_CLK     = CLOCK_25;
  assign VGA_HS      = r_vgaHs;
  assign VGA_VS      = r_vgaVs;
  assign VGA_R       = r_pix.r;
  assign VGA_G       = r_pix.g;
  assign VGA_B       = r_pix.b;
  assign VGA_BLANK_N = r_blankN;
  assign VGA_SYNC_N  = 1'b1;

endmodule
